// File: rtl/vx_delta_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vx_delta_counter_bank
//  Function : Bank of independent up/down counters with a programmable step,
//             wrap or saturate arithmetic, sticky or per-update overflow flag
//             and terminal-count compare with optional auto-clear.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_delta_counter_bank #(
    parameter int NUM_CH          = 4,
    parameter int WIDTH           = 8,
    parameter int SATURATE        = 0,
    parameter int STICKY_OVERFLOW = 0,
    parameter int AUTO_CLEAR      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       clear_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH-1:0]       down_i,
    input  logic [NUM_CH*WIDTH-1:0] delta_i,
    input  logic [NUM_CH*WIDTH-1:0] d_i,
    input  logic [NUM_CH*WIDTH-1:0] cmp_i,
    output logic [NUM_CH*WIDTH-1:0] q_o,
    output logic [NUM_CH-1:0]       overflow_o,
    output logic [NUM_CH-1:0]       tc_o
);

    // Elaboration-time switches reduced to single bits.
    localparam bit c_SATURATE   = (SATURATE != 0);
    localparam bit c_STICKY     = (STICKY_OVERFLOW != 0);
    localparam bit c_AUTO_CLEAR = (AUTO_CLEAR != 0);

    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};

    // One fully independent counter slice per channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] r_q;
        logic             r_ovf;
        logic             r_tc;

        logic [WIDTH-1:0] w_delta;
        logic [WIDTH-1:0] w_cmp;
        logic [WIDTH:0]   w_sum;
        logic [WIDTH:0]   w_diff;
        logic [WIDTH:0]   w_raw;
        logic             w_event;
        logic [WIDTH-1:0] w_arith;
        logic             w_hit;
        logic [WIDTH-1:0] w_q_next;
        logic             w_ovf_next;

        assign w_delta = delta_i[c*WIDTH +: WIDTH];
        assign w_cmp   = cmp_i[c*WIDTH +: WIDTH];

        // Extended-width add/subtract: the MSB is the carry (up) or borrow (down).
        always_comb begin
            w_sum   = {1'b0, r_q} + {1'b0, w_delta};
            w_diff  = {1'b0, r_q} - {1'b0, w_delta};
            w_raw   = down_i[c] ? w_diff : w_sum;
            w_event = w_raw[WIDTH];
        end

        // Wrap or clamp, then terminal-count compare and optional auto-clear.
        always_comb begin
            w_arith = w_raw[WIDTH-1:0];
            if (c_SATURATE && w_event) begin
                w_arith = down_i[c] ? c_ZERO : c_ALL_ONES;
            end
            // Compare uses the pre-auto-clear value so tc still pulses when cleared.
            w_hit    = (w_arith == w_cmp);
            w_q_next = (c_AUTO_CLEAR && w_hit) ? c_ZERO : w_arith;
            w_ovf_next = c_STICKY ? (r_ovf | w_event) : w_event;
        end

        // Channel state: clear beats load beats count enable; otherwise hold.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_q   <= c_ZERO;
                r_ovf <= 1'b0;
                r_tc  <= 1'b0;
            end else if (clear_i[c]) begin
                r_q   <= c_ZERO;
                r_ovf <= 1'b0;
                r_tc  <= 1'b0;
            end else if (load_i[c]) begin
                r_q   <= d_i[c*WIDTH +: WIDTH];
                r_ovf <= 1'b0;
                r_tc  <= 1'b0;
            end else if (en_i[c]) begin
                r_q   <= w_q_next;
                r_ovf <= w_ovf_next;
                r_tc  <= w_hit;
            end else begin
                r_tc  <= 1'b0;
            end
        end

        assign q_o[c*WIDTH +: WIDTH] = r_q;
        assign overflow_o[c]         = r_ovf;
        assign tc_o[c]               = r_tc;
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_delta_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_delta_counter_bank
//  Function : Self-checking bench for vx_delta_counter_bank. Two instances
//             share stimulus: A wraps / per-update overflow / no auto-clear,
//             B saturates / sticky overflow / auto-clear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vx_delta_counter_bank;

    localparam int NC = 4;
    localparam int W  = 4;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] clear, en, load, down;
    logic [NC*W-1:0] delta, d, cmp;
    logic [NC*W-1:0] q_a, q_b;
    logic [NC-1:0]   ov_a, ov_b, tc_a, tc_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NC*W-1:0] qa;
        logic [NC-1:0]   oa;
        logic [NC-1:0]   ta;
        logic [NC*W-1:0] qb;
        logic [NC-1:0]   ob;
        logic [NC-1:0]   tb;
    } exp_t;

    exp_t sb[$];

    // Reference state of both instances.
    logic [W-1:0] mq_a[NC], mq_b[NC];
    logic         mo_a[NC], mo_b[NC];

    vx_delta_counter_bank #(
        .NUM_CH(NC), .WIDTH(W), .SATURATE(0), .STICKY_OVERFLOW(0), .AUTO_CLEAR(0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .load_i(load),
        .down_i(down), .delta_i(delta), .d_i(d), .cmp_i(cmp),
        .q_o(q_a), .overflow_o(ov_a), .tc_o(tc_a)
    );

    vx_delta_counter_bank #(
        .NUM_CH(NC), .WIDTH(W), .SATURATE(1), .STICKY_OVERFLOW(1), .AUTO_CLEAR(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .load_i(load),
        .down_i(down), .delta_i(delta), .d_i(d), .cmp_i(cmp),
        .q_o(q_b), .overflow_o(ov_b), .tc_o(tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural channel model: returns {q_next, ovf_next, tc_next}.
    function automatic logic [W+1:0] mdl(input logic [W-1:0] q, input logic ov,
                                         input bit sat, input bit sticky, input bit ac,
                                         input logic cl, input logic ld, input logic e,
                                         input logic dn, input logic [W-1:0] dl,
                                         input logic [W-1:0] dv, input logic [W-1:0] cm);
        int           r;
        logic         ev;
        logic         t;
        logic [W-1:0] nq;
        if (cl) return {{W{1'b0}}, 2'b00};
        if (ld) return {dv, 2'b00};
        if (!e) return {q, ov, 1'b0};
        if (dn) begin
            r  = int'(q) - int'(dl);
            ev = (r < 0);
        end else begin
            r  = int'(q) + int'(dl);
            ev = (r > (1 << W) - 1);
        end
        nq = r[W-1:0];
        if (sat && ev) nq = dn ? {W{1'b0}} : {W{1'b1}};
        t = (nq == cm);
        if (ac && t) nq = '0;
        return {nq, (sticky ? (ov | ev) : ev), t};
    endfunction

    task automatic chk(input string tag, input logic [NC*W-1:0] obs, input logic [NC*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare against both instances.
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk("a_q",   q_a,                 e.qa);
        chk("a_ovf", {12'h0, ov_a},       {12'h0, e.oa});
        chk("a_tc",  {12'h0, tc_a},       {12'h0, e.ta});
        chk("b_q",   q_b,                 e.qb);
        chk("b_ovf", {12'h0, ov_b},       {12'h0, e.ob});
        chk("b_tc",  {12'h0, tc_b},       {12'h0, e.tb});
    endtask

    task automatic model_reset();
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            mq_a[c] = '0; mo_a[c] = 1'b0;
            mq_b[c] = '0; mo_b[c] = 1'b0;
        end
        e.qa = '0; e.oa = '0; e.ta = '0;
        e.qb = '0; e.ob = '0; e.tb = '0;
        sb.push_back(e);
    endtask

    // Apply current inputs for one clock: predict, push, clock, compare.
    task automatic step();
        exp_t         e;
        logic [W+1:0] r;
        for (int c = 0; c < NC; c++) begin
            r = mdl(mq_a[c], mo_a[c], 1'b0, 1'b0, 1'b0, clear[c], load[c], en[c], down[c],
                    delta[c*W +: W], d[c*W +: W], cmp[c*W +: W]);
            mq_a[c] = r[W+1:2]; mo_a[c] = r[1];
            e.qa[c*W +: W] = r[W+1:2]; e.oa[c] = r[1]; e.ta[c] = r[0];
            r = mdl(mq_b[c], mo_b[c], 1'b1, 1'b1, 1'b1, clear[c], load[c], en[c], down[c],
                    delta[c*W +: W], d[c*W +: W], cmp[c*W +: W]);
            mq_b[c] = r[W+1:2]; mo_b[c] = r[1];
            e.qb[c*W +: W] = r[W+1:2]; e.ob[c] = r[1]; e.tb[c] = r[0];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic idle();
        clear = '0; load = '0; en = '0; down = '0;
    endtask

    task automatic set_ch(input int c, input logic cl, input logic ld, input logic e,
                          input logic dn, input logic [W-1:0] dl, input logic [W-1:0] dv);
        clear[c] = cl; load[c] = ld; en[c] = e; down[c] = dn;
        delta[c*W +: W] = dl;
        d[c*W +: W]     = dv;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        delta = '0;
        d     = '0;
        cmp   = {NC{4'hA}};

        // Reset state, no clock edge required.
        #2;
        model_reset();
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Count ch0 to 5, then async reset between edges.
        set_ch(0, 0, 0, 1, 0, 4'd1, 4'd0);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        // Wrap vs saturate on carry; ch1 saturate-up from 13.
        set_ch(0, 0, 1, 0, 0, 4'd0, 4'd14);
        set_ch(1, 0, 1, 0, 0, 4'd0, 4'd13);
        step();
        set_ch(0, 0, 0, 1, 0, 4'd3, 4'd0);
        set_ch(1, 0, 0, 1, 0, 4'd7, 4'd0);
        step();
        set_ch(0, 0, 0, 1, 0, 4'd1, 4'd0);
        idle(); en[0] = 1'b1;
        step();

        // Borrow on down, then sticky hold across a clean update.
        set_ch(0, 0, 1, 0, 0, 4'd0, 4'd2);
        step();
        set_ch(0, 0, 0, 1, 1, 4'd5, 4'd0);
        step();
        set_ch(0, 0, 0, 1, 0, 4'd1, 4'd0);
        step();
        idle();
        step();

        // Priority: clear beats load/en, load beats en.
        set_ch(0, 1, 1, 1, 0, 4'd1, 4'd9);
        step();
        set_ch(0, 0, 1, 1, 0, 4'd1, 4'd9);
        step();

        // Terminal count at 9 with step 3.
        set_ch(0, 1, 0, 0, 0, 4'd3, 4'd0);
        step();
        cmp[3:0] = 4'd9;
        set_ch(0, 0, 0, 1, 0, 4'd3, 4'd0);
        repeat (4) step();
        idle();
        step();
        cmp[3:0] = 4'hA;

        // Independent channels: up, down across zero, held, zero step at compare.
        set_ch(0, 0, 1, 0, 0, 4'd0, 4'd0);
        set_ch(1, 0, 1, 0, 0, 4'd0, 4'd4);
        set_ch(2, 0, 1, 0, 0, 4'd0, 4'd7);
        set_ch(3, 0, 1, 0, 0, 4'd0, 4'd10);
        step();
        set_ch(0, 0, 0, 1, 0, 4'd1, 4'd0);
        set_ch(1, 0, 0, 1, 1, 4'd2, 4'd0);
        set_ch(2, 0, 0, 0, 0, 4'd5, 4'd0);
        set_ch(3, 0, 0, 1, 0, 4'd0, 4'd0);
        repeat (3) step();

        // Mixed random traffic; clear/load kept rare so counting dominates.
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < NC; c++) begin
                set_ch(c, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                       1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
                cmp[c*W +: W] = 4'($urandom);
            end
            step();
        end

        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
